comp_bit_packer: RTL and testbench

- Sits directly downstream of Compression_Top; consumes its variable-length output (valid_bits, data_out, dump).
- Concatenates the codes into a continuous MSB-first bit stream and emits fixed 64-bit words over a valid/ready interface to the storage/encryption stage.
- Drives stall back to Compression_Top when it cannot take more codes.
- Handles the end-of-stream dump by zero-padding and tagging the final partial word.

---
 rtl/comp_bit_packer.sv | 178 +++++++++++++++++
 tb/tb_comp_bit_packer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_bit_packer.sv
// Packs right-aligned variable-length codes into an MSB-first stream of WORD_W-bit words.
// Optional running bit counter on bit_count when COMP_PACKER_BITCOUNT_EN is defined.
module comp_bit_packer #(
    parameter int WORD_W        = 64,
    parameter int MAX_CODE_BITS = 20,
    parameter int ACC_W         = 128,
    parameter int CNT_W         = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CNT_W-1:0]  in_valid_bits,
    input  logic [WORD_W-1:0] in_data,
    input  logic              dump,
    output logic              stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_bits,
    output logic              out_last,
    output logic              flush_done,
    output logic              err,
    output logic [31:0]       bit_count
);

    localparam int CW1 = CNT_W + 1;
    localparam logic [CNT_W:0] WORD_L = CW1'(WORD_W);
    localparam logic [CNT_W:0] ACC_L  = CW1'(ACC_W);
    localparam logic [CNT_W:0] MAX_L  = CW1'(MAX_CODE_BITS);

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_EMIT, ST_DONE} state_t;

    state_t            state_reg, state_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0]  fill_reg, fill_next;
    logic [WORD_W-1:0] out_data_reg, out_data_next;
    logic [CNT_W-1:0]  out_bits_reg, out_bits_next;
    logic              out_valid_reg, out_valid_next;
    logic              out_last_reg, out_last_next;
    logic              stall_reg, stall_next;
    logic              flush_done_reg, flush_done_next;
    logic              err_reg, err_next;

    logic [WORD_W-1:0] code_mask;
    logic [CNT_W:0]    sum_bits;
    logic [CNT_W:0]    fill_app;
    logic [ACC_W-1:0]  code_ext;
    logic [ACC_W-1:0]  acc_app;
    logic              code_present;
    logic              code_take;
    logic              out_free;
    logic              xfer;

    // Keep only the low in_valid_bits of in_data; anything above is not part of the code.
    generate
        for (genvar gi = 0; gi < WORD_W; gi++) begin : g_mask
            assign code_mask[gi] = (32'(gi) < 32'(in_valid_bits));
        end
    endgenerate

    always_comb begin
        sum_bits     = {1'b0, fill_reg} + {1'b0, in_valid_bits};
        code_present = (in_valid_bits != '0);
        code_take    = code_present && ({1'b0, in_valid_bits} <= MAX_L) && (sum_bits <= ACC_L);
        // The new code lands directly below the current fill, keeping the stream MSB-aligned.
        code_ext     = {{(ACC_W-WORD_W){1'b0}}, in_data & code_mask} << (ACC_L - sum_bits);
        acc_app      = code_take ? (acc_reg | code_ext) : acc_reg;
        fill_app     = code_take ? sum_bits : {1'b0, fill_reg};
        out_free     = !out_valid_reg || out_ready;
        xfer         = out_free && (fill_app >= WORD_L);

        acc_next        = acc_app;
        fill_next       = fill_app[CNT_W-1:0];
        out_data_next   = out_data_reg;
        out_bits_next   = out_bits_reg;
        out_last_next   = out_last_reg;
        out_valid_next  = out_valid_reg && !out_ready;
        state_next      = state_reg;
        flush_done_next = 1'b0;
        err_next        = err_reg || (code_present && !code_take)
                          || (dump && (state_reg != ST_RUN));

        if (xfer) begin
            out_data_next  = acc_app[ACC_W-1 -: WORD_W];
            out_bits_next  = CNT_W'(WORD_W);
            out_last_next  = 1'b0;
            out_valid_next = 1'b1;
            acc_next       = acc_app << WORD_W;
            fill_next      = CNT_W'(fill_app - WORD_L);
        end

        case (state_reg)
            ST_RUN: begin
                if (dump) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fill_app < WORD_L) begin
                    state_next = (fill_app == '0) ? ST_DONE : ST_EMIT;
                end
            end
            ST_EMIT: begin
                // Residual bits go out zero-padded; the low positions of acc are already zero.
                if (!xfer && out_free) begin
                    if (fill_app != '0) begin
                        out_data_next  = acc_app[ACC_W-1 -: WORD_W];
                        out_bits_next  = fill_app[CNT_W-1:0];
                        out_last_next  = 1'b1;
                        out_valid_next = 1'b1;
                    end
                    acc_next   = '0;
                    fill_next  = '0;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                flush_done_next = 1'b1;
                state_next      = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        stall_next = (({1'b0, fill_next} >= WORD_L) && out_valid_next) || (state_next != ST_RUN);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_RUN;
            acc_reg        <= '0;
            fill_reg       <= '0;
            out_data_reg   <= '0;
            out_bits_reg   <= '0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            stall_reg      <= 1'b0;
            flush_done_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            fill_reg       <= fill_next;
            out_data_reg   <= out_data_next;
            out_bits_reg   <= out_bits_next;
            out_valid_reg  <= out_valid_next;
            out_last_reg   <= out_last_next;
            stall_reg      <= stall_next;
            flush_done_reg <= flush_done_next;
            err_reg        <= err_next;
        end
    end

    assign stall      = stall_reg;
    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_bits   = out_bits_reg;
    assign out_last   = out_last_reg;
    assign flush_done = flush_done_reg;
    assign err        = err_reg;

`ifdef COMP_PACKER_BITCOUNT_EN
    logic [31:0] bit_count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_count_reg <= '0;
        end else if (code_take) begin
            bit_count_reg <= bit_count_reg + 32'(in_valid_bits);
        end
    end

    assign bit_count = bit_count_reg;
`else
    assign bit_count = '0;
`endif

endmodule

// File: tb/tb_comp_bit_packer.sv
// Scoreboard bench for comp_bit_packer: directed codes push expected words, a negedge monitor checks them.
module tb_comp_bit_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  in_valid_bits;
    logic [63:0] in_data;
    logic        dump;
    logic        stall;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_bits;
    logic        out_last;
    logic        flush_done;
    logic        err;
    logic [31:0] bit_count;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  bits;
        logic        last;
    } word_t;

    word_t exp_q[$];
    int    n_checks = 0;
    int    n_pass = 0;
    int    flush_cnt = 0;
    int    words_seen = 0;
    int    exp_bits = 0;
    logic  hold_prev = 1'b0;
    word_t held;

    comp_bit_packer dut (
        .clock(clock),
        .reset(reset),
        .in_valid_bits(in_valid_bits),
        .in_data(in_data),
        .dump(dump),
        .stall(stall),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_bits(out_bits),
        .out_last(out_last),
        .flush_done(flush_done),
        .err(err),
        .bit_count(bit_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    function automatic logic [31:0] exp_bc();
`ifdef COMP_PACKER_BITCOUNT_EN
        return 32'(exp_bits);
`else
        return 32'd0;
`endif
    endfunction

    task automatic put(input logic [7:0] n, input logic [63:0] d, input logic dmp);
        @(posedge clock);
        #1;
        in_valid_bits = n;
        in_data       = d;
        dump          = dmp;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) put(8'd0, 64'd0, 1'b0);
    endtask

    task automatic push(input logic [63:0] d, input logic [7:0] b, input logic l);
        word_t w;
        w.data = d;
        w.bits = b;
        w.last = l;
        exp_q.push_back(w);
    endtask

    task automatic drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 200) begin
            @(posedge clock);
            c++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_flush(input int target);
        int c = 0;
        while (flush_cnt < target && c < 50) begin
            @(posedge clock);
            c++;
        end
        check("flush_done_count", 64'(flush_cnt), 64'(target));
    endtask

    // Monitor: scoreboard pop on each handshake, plus output-hold check while back-pressured.
    always @(negedge clock) begin
        word_t e;
        if (reset) begin
            if (hold_prev && out_valid) begin
                check("hold_data", out_data, held.data);
                check("hold_bits", 64'(out_bits), 64'(held.bits));
                check("hold_last", 64'(out_last), 64'(held.last));
            end
            if (out_valid && out_ready) begin
                words_seen++;
                $display("word data=%h bits=%0d last=%0d", out_data, out_bits, out_last);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got %h, required no word", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", out_data, e.data);
                    check("word_bits", 64'(out_bits), 64'(e.bits));
                    check("word_last", 64'(out_last), 64'(e.last));
                end
            end
            if (flush_done) flush_cnt++;
            hold_prev = out_valid && !out_ready;
            held.data = out_data;
            held.bits = out_bits;
            held.last = out_last;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    logic [19:0] t4_codes [8];
    int          fd0;
    int          ws0;
    int          i4;
    int          cyc;
    logic        prev_stall;
    logic        seen_stall;

    initial begin
        reset         = 1'b0;
        in_valid_bits = '0;
        in_data       = '0;
        dump          = 1'b0;
        out_ready     = 1'b1;
        t4_codes = '{20'h01234, 20'h56789, 20'hABCDE, 20'hFFEDC,
                     20'hBA987, 20'h65432, 20'h105A5, 20'hA5A5A};

        repeat (2) @(negedge clock);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_bits", 64'(out_bits), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_bit_count", 64'(bit_count), 64'd0);
        @(posedge clock);
        #1 reset = 1'b1;

        // Sixteen 4-bit 0xA codes; upper in_data bits carry junk that must be ignored.
        push(64'hAAAA_AAAA_AAAA_AAAA, 8'd64, 1'b0);
        repeat (16) begin
            put(8'd4, {60'h0123456789ABCDE, 4'hA}, 1'b0);
            exp_bits += 4;
        end
        idle(1);
        drain("drain_t1");

        // 60 ones then 0000.
        push(64'hFFFF_FFFF_FFFF_FFF0, 8'd64, 1'b0);
        repeat (3) put(8'd20, 64'hFFFFF, 1'b0);
        put(8'd4, 64'h0, 1'b0);
        exp_bits += 64;
        idle(1);
        drain("drain_t2");

        // 65 bits then dump: one full word and a 1-bit tail.
        push(64'hFFFF_FFFF_FFFF_F000, 8'd64, 1'b0);
        push(64'h8000_0000_0000_0000, 8'd1, 1'b1);
        fd0 = flush_cnt;
        repeat (4) put(8'd13, 64'h1FFF, 1'b0);
        put(8'd13, 64'h0001, 1'b0);
        put(8'd0, 64'd0, 1'b1);
        exp_bits += 65;
        idle(1);
        wait_flush(fd0 + 1);
        drain("drain_t3");
        idle(4);
        check("flush_once_t3", 64'(flush_cnt), 64'(fd0 + 1));

        // Back-pressure: upstream reacts to stall one cycle late.
        out_ready = 1'b0;
        push(64'h0123_4567_89AB_CDEF, 8'd64, 1'b0);
        push(64'hFEDC_BA98_7654_3210, 8'd64, 1'b0);
        push(64'h5A5A_5A5A_0000_0000, 8'd32, 1'b1);
        prev_stall = 1'b0;
        seen_stall = 1'b0;
        i4 = 0;
        cyc = 0;
        while (i4 < 8 && cyc < 100) begin
            if (!prev_stall) begin
                put(8'd20, {44'h0, t4_codes[i4]}, 1'b0);
                i4++;
            end else begin
                put(8'd0, 64'd0, 1'b0);
            end
            prev_stall = stall;
            if (stall) seen_stall = 1'b1;
            cyc++;
        end
        check("t4_codes_sent", 64'(i4), 64'd8);
        idle(3);
        if (stall) seen_stall = 1'b1;
        check("t4_stall_rose", 64'(seen_stall), 64'd1);
        check("t4_stall_held", 64'(stall), 64'd1);
        check("t4_out_valid", 64'(out_valid), 64'd1);
        check("t4_err", 64'(err), 64'd0);
        exp_bits += 160;
        put(8'd0, 64'd0, 1'b0);
        out_ready = 1'b1;
        idle(2);
        check("t4_stall_released", 64'(stall), 64'd0);
        fd0 = flush_cnt;
        put(8'd0, 64'd0, 1'b1);
        idle(1);
        wait_flush(fd0 + 1);
        drain("drain_t4");

        // Oversized code is dropped; dump on an empty accumulator emits nothing.
        check("t5_err_before", 64'(err), 64'd0);
        put(8'd21, 64'h1F_FFFF, 1'b0);
        put(8'd0, 64'd0, 1'b0);
        check("t5_err_set", 64'(err), 64'd1);
        fd0 = flush_cnt;
        ws0 = words_seen;
        put(8'd0, 64'd0, 1'b1);
        idle(1);
        wait_flush(fd0 + 1);
        idle(4);
        check("t5_no_word", 64'(words_seen), 64'(ws0));
        check("t5_flush_once", 64'(flush_cnt), 64'(fd0 + 1));
        check("t5_bit_count", 64'(bit_count), 64'(exp_bc()));

        // Reset mid-word with one word held and 37 bits pending.
        out_ready = 1'b0;
        repeat (5) put(8'd20, 64'hFFFFF, 1'b0);
        put(8'd1, 64'h1, 1'b0);
        exp_bits += 101;
        idle(3);
        check("t6_word_held", 64'(out_valid), 64'd1);
        check("t6_bit_count_pre", 64'(bit_count), 64'(exp_bc()));
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        exp_bits = 0;
        check("t6_rst_out_valid", 64'(out_valid), 64'd0);
        check("t6_rst_out_data", out_data, 64'd0);
        check("t6_rst_err", 64'(err), 64'd0);
        check("t6_rst_stall", 64'(stall), 64'd0);
        check("t6_rst_bit_count", 64'(bit_count), 64'(exp_bc()));
        @(posedge clock);
        #1;
        reset = 1'b1;
        out_ready = 1'b1;
        push(64'hABCD_E123_4567_89AB, 8'd64, 1'b0);
        put(8'd20, 64'hABCDE, 1'b0);
        put(8'd20, 64'h12345, 1'b0);
        put(8'd20, 64'h6789A, 1'b0);
        put(8'd4, 64'hB, 1'b0);
        exp_bits += 64;
        idle(1);
        drain("drain_t6");
        check("t6_bit_count_post", 64'(bit_count), 64'(exp_bc()));
        check("t6_err_post", 64'(err), 64'd0);

        idle(3);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
